rr_arbiter_8x3: RTL and testbench

- Round-robin arbiter that shares one 3-bit index path between 8 requesters.
- Sequential counterpart of the team's combinational 8-to-3 encoder: accepts a multi-hot request vector and grants exactly one requester.
- Grant is presented both one-hot and binary-encoded, for downstream mux/decoder select.
- Sits between requesting agents and the shared resource.

---
 rtl/rr_arbiter_8x3.sv | 168 ++++++++++++++++
 tb/tb_rr_arbiter_8x3.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/rr_arbiter_8x3.sv
// rr_arbiter_8x3: round-robin arbiter for 8 requesters.
// The grant is registered and presented both one-hot (gnt) and encoded (gnt_idx).
// Optional feature: define RR_ARB_TIMEOUT_EN to limit how long one owner may keep
// the grant (MAX_HOLD cycles) while other requesters are waiting.
module rr_arbiter_8x3 #(
    parameter int N        = 8,
    parameter int IDXW     = 3,
    parameter int MAX_HOLD = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N-1:0]    req,
    output logic [N-1:0]    gnt,
    output logic [IDXW-1:0] gnt_idx,
    output logic            gnt_vld,
    output logic            busy_err
);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_OWNED = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [IDXW-1:0] ptr_q, ptr_d;
    logic [N-1:0]    gnt_q, gnt_d;
    logic [IDXW-1:0] gnt_idx_q, gnt_idx_d;
    logic            gnt_vld_q, gnt_vld_d;
    logic            busy_err_q, busy_err_d;

    logic [IDXW:0]   pick_idle;   // {found, index} scanning from ptr_q
    logic [IDXW:0]   pick_rot;    // {found, index} scanning past the current owner
    logic [IDXW:0]   win_sel;
    logic [IDXW-1:0] win_idx;
    logic [N-1:0]    win_onehot;
    logic [IDXW-1:0] ptr_rot;
    logic            force_rot;
    logic            take_new;

    // First set bit of r, scanning from start upward and wrapping modulo N.
    // The loop walks offsets from farthest to nearest so the nearest hit wins.
    function automatic logic [IDXW:0] pick_from(input logic [N-1:0] r,
                                                 input logic [IDXW-1:0] start);
        logic [IDXW:0]   res;
        logic [IDXW-1:0] cand;
        res = '0;
        for (int off = N - 1; off >= 0; off--) begin
            cand = start + IDXW'(off);
            if (r[cand]) begin
                res = {1'b1, cand};
            end
        end
        return res;
    endfunction

    assign ptr_rot   = gnt_idx_q + IDXW'(1);
    assign pick_idle = pick_from(req, ptr_q);
    // The owner is masked so a forced rotation can never re-grant it.
    assign pick_rot  = pick_from(req & ~gnt_q, ptr_rot);
    assign win_sel   = (state_q == ST_IDLE) ? pick_idle : pick_rot;
    assign win_idx   = win_sel[IDXW-1:0];

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_win_dec
            assign win_onehot[gi] = (win_idx == IDXW'(gi));
        end
    endgenerate

`ifdef RR_ARB_TIMEOUT_EN
    localparam logic [3:0] HOLD_LAST = 4'(MAX_HOLD - 1);

    logic [3:0] hold_cnt_q, hold_cnt_d;
    logic       at_limit;

    assign at_limit  = (hold_cnt_q == HOLD_LAST);
    assign force_rot = at_limit && (|(req & ~gnt_q));

    // Count cycles of ownership; restart on every new grant, in IDLE and at the limit.
    always_comb begin
        hold_cnt_d = hold_cnt_q;
        if (take_new || state_d != ST_OWNED || at_limit) begin
            hold_cnt_d = '0;
        end else begin
            hold_cnt_d = hold_cnt_q + 4'd1;
        end
    end

    // Hold counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_cnt_q <= '0;
        end else begin
            hold_cnt_q <= hold_cnt_d;
        end
    end
`else
    logic unused_max_hold;
    assign unused_max_hold = ^4'(MAX_HOLD);
    assign force_rot       = 1'b0;
`endif

    // Arbitration: grant from IDLE, hold while the owner requests, rotate on release.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        gnt_d     = gnt_q;
        gnt_idx_d = gnt_idx_q;
        gnt_vld_d = gnt_vld_q;
        take_new  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                take_new = win_sel[IDXW];
            end
            ST_OWNED: begin
                if (!req[gnt_idx_q] || force_rot) begin
                    ptr_d = ptr_rot;
                    if (win_sel[IDXW]) begin
                        take_new = 1'b1;
                    end else begin
                        state_d   = ST_IDLE;
                        gnt_d     = '0;
                        gnt_idx_d = '0;
                        gnt_vld_d = 1'b0;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if (take_new) begin
            state_d   = ST_OWNED;
            gnt_d     = win_onehot;
            gnt_idx_d = win_idx;
            gnt_vld_d = 1'b1;
        end
    end

    // Self-check: flag permanently if the registered grant ever has two bits set.
    always_comb begin
        busy_err_d = busy_err_q | (|(gnt_q & (gnt_q - N'(1))));
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            ptr_q      <= '0;
            gnt_q      <= '0;
            gnt_idx_q  <= '0;
            gnt_vld_q  <= 1'b0;
            busy_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            gnt_q      <= gnt_d;
            gnt_idx_q  <= gnt_idx_d;
            gnt_vld_q  <= gnt_vld_d;
            busy_err_q <= busy_err_d;
        end
    end

    assign gnt      = gnt_q;
    assign gnt_idx  = gnt_idx_q;
    assign gnt_vld  = gnt_vld_q;
    assign busy_err = busy_err_q;

endmodule

// File: tb/tb_rr_arbiter_8x3.sv
// Testbench for rr_arbiter_8x3: directed vector table, hand-written corner
// sequences and randomized requests checked against a priority-list model.
// Define RR_ARB_TIMEOUT_EN for both files to exercise the hold-limit feature.
module tb_rr_arbiter_8x3;

    localparam int MAX_HOLD = 4;
`ifdef RR_ARB_TIMEOUT_EN
    localparam bit TIMEOUT = 1'b1;
`else
    localparam bit TIMEOUT = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] req = 8'h00;
    logic [7:0] gnt;
    logic [2:0] gnt_idx;
    logic       gnt_vld;
    logic       busy_err;

    int n_vec = 0;
    int n_err = 0;

    rr_arbiter_8x3 #(.N(8), .IDXW(3), .MAX_HOLD(MAX_HOLD)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req),
        .gnt      (gnt),
        .gnt_idx  (gnt_idx),
        .gnt_vld  (gnt_vld),
        .busy_err (busy_err)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected $finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [7:0] req;
        logic [7:0] gnt;
        logic [2:0] idx;
        logic       vld;
    } vec_t;

    // ---------------- reference model: owner + next-priority index ----------------
    int m_owner;   // -1 when nobody holds the grant
    int m_next;    // requester with highest priority at the next arbitration
    int m_held;    // number of cycles the current owner has visibly held the grant

    function automatic void model_reset();
        m_owner = -1;
        m_next  = 0;
        m_held  = 0;
    endfunction

    function automatic int first_from(input logic [7:0] r, input int start, input int skip);
        for (int k = 0; k < 8; k++) begin
            int i;
            i = (start + k) % 8;
            if (i != skip && r[i]) return i;
        end
        return -1;
    endfunction

    function automatic void model_step(input logic [7:0] r);
        logic [7:0] one;
        bit others;
        bit expire;
        one = 8'h01;
        if (m_owner < 0) begin
            m_owner = first_from(r, m_next, -1);
            m_held  = (m_owner >= 0) ? 1 : 0;
        end else begin
            others = (r & ~(one << m_owner)) != 8'h00;
            expire = TIMEOUT && (m_held == MAX_HOLD) && others;
            if (!r[m_owner] || expire) begin
                m_next  = (m_owner + 1) % 8;
                m_owner = first_from(r, m_next, m_owner);
                m_held  = (m_owner >= 0) ? 1 : 0;
            end else begin
                m_held = (m_held == MAX_HOLD) ? 1 : m_held + 1;
            end
        end
    endfunction

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [7:0] eg,
                         input logic [2:0] ei, input logic ev);
        n_vec++;
        if (gnt !== eg || gnt_idx !== ei || gnt_vld !== ev || busy_err !== 1'b0) begin
            n_err++;
            $display("FAIL %s: req=%h got gnt=%h idx=%0d vld=%b err=%b, expected gnt=%h idx=%0d vld=%b err=0",
                     name, req, gnt, gnt_idx, gnt_vld, busy_err, eg, ei, ev);
        end else begin
            $display("ok   %s: req=%h gnt=%h idx=%0d vld=%b", name, req, gnt, gnt_idx, gnt_vld);
        end
    endtask

    task automatic step(input logic [7:0] r);
        req = r;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        req   = 8'h00;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("reset", 8'h00, 3'd0, 1'b0);
        rst_n = 1'b1;
    endtask

    vec_t vt[18];

    initial begin
        logic [7:0] one;
        logic [7:0] r;
        logic [7:0] eg;
        logic [2:0] ei;
        one = 8'h01;

        // fairness, wrap back to 0, single requester, pointer wrap past 7
        vt[0]  = '{8'hFF, 8'h01, 3'd0, 1'b1};
        vt[1]  = '{8'hFE, 8'h02, 3'd1, 1'b1};
        vt[2]  = '{8'hFC, 8'h04, 3'd2, 1'b1};
        vt[3]  = '{8'hF8, 8'h08, 3'd3, 1'b1};
        vt[4]  = '{8'hF0, 8'h10, 3'd4, 1'b1};
        vt[5]  = '{8'hE0, 8'h20, 3'd5, 1'b1};
        vt[6]  = '{8'hC0, 8'h40, 3'd6, 1'b1};
        vt[7]  = '{8'h80, 8'h80, 3'd7, 1'b1};
        vt[8]  = '{8'h00, 8'h00, 3'd0, 1'b0};
        vt[9]  = '{8'hFF, 8'h01, 3'd0, 1'b1};
        vt[10] = '{8'h00, 8'h00, 3'd0, 1'b0};
        vt[11] = '{8'h04, 8'h04, 3'd2, 1'b1};
        vt[12] = '{8'h00, 8'h00, 3'd0, 1'b0};
        vt[13] = '{8'h20, 8'h20, 3'd5, 1'b1};
        vt[14] = '{8'h00, 8'h00, 3'd0, 1'b0};
        vt[15] = '{8'h41, 8'h40, 3'd6, 1'b1};
        vt[16] = '{8'h01, 8'h01, 3'd0, 1'b1};
        vt[17] = '{8'h00, 8'h00, 3'd0, 1'b0};

        // reset state
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset", 8'h00, 3'd0, 1'b0);
        rst_n = 1'b1;

        for (int i = 0; i < 18; i++) begin
            step(vt[i].req);
            check($sformatf("table[%0d]", i), vt[i].gnt, vt[i].idx, vt[i].vld);
        end

        // reset asserted between edges while a grant is held
        do_reset();
        step(8'h10);
        check("midrst_grant", 8'h10, 3'd4, 1'b1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_async", 8'h00, 3'd0, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(8'h11);
        check("midrst_first", 8'h01, 3'd0, 1'b1);

        do_reset();
`ifdef RR_ARB_TIMEOUT_EN
        // two contenders alternate every MAX_HOLD cycles
        for (int k = 0; k < 16; k++) begin
            step(8'h03);
            ei = 3'((k / MAX_HOLD) % 2);
            eg = one << ei;
            check($sformatf("timeout_alt[%0d]", k), eg, ei, 1'b1);
        end
        // lone requester keeps the grant past the limit
        for (int k = 0; k < 12; k++) begin
            step(8'h01);
            check($sformatf("timeout_lone[%0d]", k), 8'h01, 3'd0, 1'b1);
        end
`else
        // without the limit the first owner keeps the grant indefinitely
        for (int k = 0; k < 20; k++) begin
            step(8'h03);
            check($sformatf("hold[%0d]", k), 8'h01, 3'd0, 1'b1);
        end
`endif

        // randomized requests against the model
        do_reset();
        model_reset();
        r = 8'($urandom);
        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(0, 15) == 0) begin
                r = 8'h00;
            end else begin
                r = r ^ 8'($urandom & $urandom & $urandom);
            end
            step(r);
            model_step(r);
            eg = (m_owner >= 0) ? (one << m_owner) : 8'h00;
            ei = (m_owner >= 0) ? 3'(m_owner) : 3'd0;
            check($sformatf("rand[%0d]", k), eg, ei, m_owner >= 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
